// File: rtl/move_list_buffer.sv
// Move list buffer: serialises bundles of checker moves into HI (capture/promo)
// and LO priority queues, then drains them HI-first over a valid/ready port.
module move_list_buffer #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          gen_done,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [16*NUM_PORTS-1:0]       in_move,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [15:0]                   out_move,
  input  logic                          out_ready,
  output logic [$clog2(2*DEPTH):0]      count,
  output logic                          overflow,
  output logic                          done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(2*DEPTH) + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [NUM_PORTS-1:0] PEND_ZERO = {NUM_PORTS{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                   state_r, next_state_s;
  logic [16*NUM_PORTS-1:0]  stage_r;
  logic [NUM_PORTS-1:0]     pend_r, low_s;
  logic [15:0]              sel_move_s;
  logic [15:0]              hi_mem_r [DEPTH];
  logic [15:0]              lo_mem_r [DEPTH];
  logic [AW-1:0]            hi_wp_r, hi_rp_r, lo_wp_r, lo_rp_r;
  logic [CW-1:0]            hi_cnt_r, lo_cnt_r;
  logic                     overflow_r, done_r, done_set_s;
  logic                     accept_s, ser_en_s, to_hi_s;
  logic                     hi_wr_s, lo_wr_s, drop_s;
  logic                     hi_empty_s, lo_empty_s, pop_hi_s, pop_lo_s;

  assign hi_empty_s = (hi_cnt_r == CNT_ZERO);
  assign lo_empty_s = (lo_cnt_r == CNT_ZERO);
  assign in_ready   = (state_r == S_COLLECT) && (pend_r == PEND_ZERO);
  assign accept_s   = in_ready && (|in_valid);
  assign ser_en_s   = ((state_r == S_COLLECT) || (state_r == S_FLUSH)) && (pend_r != PEND_ZERO);
  // Two's-complement trick isolates the lowest set pending bit as a one-hot mask
  assign low_s      = pend_r & (~pend_r + NUM_PORTS'(1));
  assign to_hi_s    = sel_move_s[12] | sel_move_s[13];
  assign hi_wr_s    = ser_en_s && to_hi_s && (hi_cnt_r != CNT_FULL);
  assign lo_wr_s    = ser_en_s && !to_hi_s && (lo_cnt_r != CNT_FULL);
  assign drop_s     = ser_en_s && !hi_wr_s && !lo_wr_s;
  assign out_valid  = (state_r == S_DRAIN) && !(hi_empty_s && lo_empty_s);
  assign pop_hi_s   = out_valid && out_ready && !hi_empty_s;
  assign pop_lo_s   = out_valid && out_ready && hi_empty_s;
  assign count      = NW'(hi_cnt_r) + NW'(lo_cnt_r);
  assign overflow   = overflow_r;
  assign done       = done_r;

  // Mux the staged move selected by the one-hot lowest pending bit
  always_comb begin
    sel_move_s = 16'h0000;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_move_s = sel_move_s | (stage_r[16*i +: 16] & {16{low_s[i]}});
    end
  end

  // Head presentation: HI queue has priority over LO
  always_comb begin
    out_move = 16'h0000;
    if (!out_valid) begin
      out_move = 16'h0000;
    end else if (!hi_empty_s) begin
      out_move = hi_mem_r[hi_rp_r];
    end else begin
      out_move = lo_mem_r[lo_rp_r];
    end
  end

  // Next-state logic; start restarts collection from any state
  always_comb begin
    next_state_s = state_r;
    done_set_s   = 1'b0;
    if (start) begin
      next_state_s = S_COLLECT;
    end else begin
      case (state_r)
        S_IDLE:    next_state_s = S_IDLE;
        S_COLLECT: next_state_s = gen_done ? S_FLUSH : S_COLLECT;
        S_FLUSH:   next_state_s = (pend_r == PEND_ZERO) ? S_DRAIN : S_FLUSH;
        S_DRAIN: begin
          if (hi_empty_s && lo_empty_s) begin
            next_state_s = S_IDLE;
            done_set_s   = 1'b1;
          end else begin
            next_state_s = S_DRAIN;
          end
        end
        default:   next_state_s = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Staging, pointers, occupancy counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      stage_r    <= {(16*NUM_PORTS){1'b0}};
      pend_r     <= PEND_ZERO;
      hi_wp_r    <= AW'(0);
      hi_rp_r    <= AW'(0);
      lo_wp_r    <= AW'(0);
      lo_rp_r    <= AW'(0);
      hi_cnt_r   <= CNT_ZERO;
      lo_cnt_r   <= CNT_ZERO;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        stage_r <= in_move;
        pend_r  <= in_valid;
      end else if (ser_en_s) begin
        pend_r  <= pend_r & ~low_s;
      end
      // Writes and pops are mutually exclusive by state, so one update per queue
      if (hi_wr_s) begin
        hi_wp_r  <= hi_wp_r + PTR_ONE;
        hi_cnt_r <= hi_cnt_r + CNT_ONE;
      end else if (pop_hi_s) begin
        hi_rp_r  <= hi_rp_r + PTR_ONE;
        hi_cnt_r <= hi_cnt_r - CNT_ONE;
      end
      if (lo_wr_s) begin
        lo_wp_r  <= lo_wp_r + PTR_ONE;
        lo_cnt_r <= lo_cnt_r + CNT_ONE;
      end else if (pop_lo_s) begin
        lo_rp_r  <= lo_rp_r + PTR_ONE;
        lo_cnt_r <= lo_cnt_r - CNT_ONE;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (done_set_s) begin
        done_r <= 1'b1;
      end
    end
  end

  // Queue storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (hi_wr_s) begin
      hi_mem_r[hi_wp_r] <= sel_move_s;
    end
    if (lo_wr_s) begin
      lo_mem_r[lo_wp_r] <= sel_move_s;
    end
  end

endmodule

// File: tb/tb_move_list_buffer.sv
// Self-checking bench for move_list_buffer: directed steps plus random bundles
// compared against a queue-based priority model.
module tb_move_list_buffer;

  localparam int NP    = 4;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n, start, gen_done, out_ready;
  logic [3:0]  in_valid;
  logic [63:0] in_move;
  logic        in_ready, out_valid, overflow, done;
  logic [15:0] out_move;
  logic [6:0]  count;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [15:0] hi_q[$];
  logic [15:0] lo_q[$];
  bit          ovf_m;

  always #5 clk = ~clk;

  move_list_buffer #(.NUM_PORTS(NP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gen_done(gen_done),
    .in_valid(in_valid), .in_move(in_move), .in_ready(in_ready),
    .out_valid(out_valid), .out_move(out_move), .out_ready(out_ready),
    .count(count), .overflow(overflow), .done(done)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] gen_move(input int kind);
    logic [15:0] m;
    m = {4'b0000, 12'($urandom)};
    case (kind)
      1:       m[12] = 1'b1;
      2:       m[13] = 1'b1;
      3:       m = {1'b0, 15'($urandom)};
      default: m = m;
    endcase
    return m;
  endfunction

  // Reference: lowest port first; capture/promo to HI, else LO; full queue drops
  function automatic void model_push(input logic [3:0] v, input logic [63:0] mv);
    logic [15:0] m;
    for (int i = 0; i < NP; i++) begin
      if (v[i]) begin
        m = mv[16*i +: 16];
        if (m[12] || m[13]) begin
          if (hi_q.size() < DEPTH) hi_q.push_back(m);
          else ovf_m = 1'b1;
        end else begin
          if (lo_q.size() < DEPTH) lo_q.push_back(m);
          else ovf_m = 1'b1;
        end
      end
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    hi_q.delete();
    lo_q.delete();
    ovf_m = 1'b0;
    check("start_in_ready", in_ready, 1);
    check("start_count", count, 0);
  endtask

  task automatic send(input logic [3:0] v, input logic [63:0] mv);
    wait_ready();
    in_valid = v;
    in_move  = mv;
    tick();
    in_valid = 4'b0000;
    in_move  = {$urandom, $urandom};
    model_push(v, mv);
    wait_ready();
    check("bundle_count", count, hi_q.size() + lo_q.size());
  endtask

  task automatic finish_pass(input int flush_ticks);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    repeat (flush_ticks) tick();
  endtask

  // mode 0: always ready, 1: repeating 1,0,0,1, 2: random
  task automatic drain(input int mode);
    int          cyc = 0;
    int          lim;
    logic        rdy;
    logic [15:0] exp_m;
    logic [3:0]  pat;
    pat = 4'b1001;
    lim = 4 * (hi_q.size() + lo_q.size()) + 20;
    while ((hi_q.size() + lo_q.size()) > 0 && cyc < lim) begin
      exp_m = (hi_q.size() > 0) ? hi_q[0] : lo_q[0];
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      check("drain_valid", out_valid, 1);
      check("drain_move", out_move, exp_m);
      tick();
      if (rdy) begin
        if (hi_q.size() > 0) void'(hi_q.pop_front());
        else void'(lo_q.pop_front());
      end
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_timeout", cyc < lim, 1);
    check("drain_empty_valid", out_valid, 0);
    check("drain_overflow", overflow, ovf_m);
    tick();
    check("pass_done", done, 1);
    check("pass_count", count, 0);
  endtask

  initial begin
    logic [63:0] mv;
    logic [3:0]  v;
    int          nb;
    rst_n = 1'b0; start = 1'b0; gen_done = 1'b0; out_ready = 1'b0;
    in_valid = 4'b0000; in_move = 64'h0;
    ovf_m = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_move", out_move, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Basic bundle 1011: A quiet, B capture, D quiet; port 2 must be ignored
    do_start();
    in_valid = 4'b1011;
    in_move  = {16'h0789, 16'h2FFF, 16'h1456, 16'h0321};
    tick();
    model_push(in_valid, in_move);
    in_valid = 4'b0000;
    check("t1_count0", count, 0);
    check("t1_busy", in_ready, 0);
    tick(); check("t1_count1", count, 1);
    tick(); check("t1_count2", count, 2);
    tick(); check("t1_count3", count, 3);
    check("t1_ready", in_ready, 1);
    check("t1_done_low", done, 0);
    finish_pass(1);
    drain(0);

    // Promo priority across separate bundles
    do_start();
    send(4'b0001, {48'h0, 16'h0123});
    send(4'b0001, {48'h0, 16'h2456});
    finish_pass(1);
    drain(0);

    // Overflow: DEPTH+2 captures into HI
    do_start();
    for (int b = 0; b < 8; b++) begin
      send(4'b1111, {gen_move(1), gen_move(1), gen_move(1), gen_move(1)});
    end
    send(4'b0011, {32'h0, gen_move(1), gen_move(1)});
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, DEPTH);
    finish_pass(1);
    drain(2);

    // gen_done coincident with a 4-move accept; inputs changed during FLUSH
    do_start();
    mv = {gen_move(3), gen_move(3), gen_move(3), gen_move(3)};
    in_valid = 4'b1111; in_move = mv; gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    model_push(4'b1111, mv);
    in_move = {gen_move(1), gen_move(2), gen_move(1), gen_move(2)};
    for (int i = 0; i < 4; i++) begin
      check("flush_not_ready", in_ready, 0);
      tick();
    end
    check("flush_count", count, 4);
    tick();
    in_valid = 4'b0000;
    drain(0);

    // Backpressure 1,0,0,1 over random bundles (zero-valid bundles included)
    do_start();
    for (int b = 0; b < 6; b++) begin
      v = 4'($urandom);
      send(v, {gen_move(3), gen_move(3), gen_move(3), gen_move(3)});
    end
    finish_pass(1);
    drain(1);

    // Random passes, random readiness
    for (int p = 0; p < 3; p++) begin
      do_start();
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        v = 4'($urandom);
        send(v, {gen_move($urandom_range(0, 3)), gen_move($urandom_range(0, 3)),
                 gen_move($urandom_range(0, 3)), gen_move($urandom_range(0, 3))});
      end
      finish_pass(1);
      drain(2);
    end

    // Empty pass: DRAIN to IDLE in one cycle
    do_start();
    finish_pass(1);
    drain(0);

    // start mid-DRAIN with 5 entries left
    do_start();
    send(4'b1111, {gen_move(3), gen_move(3), gen_move(3), gen_move(3)});
    send(4'b1111, {gen_move(3), gen_move(3), gen_move(3), gen_move(3)});
    finish_pass(1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_move", out_move, (hi_q.size() > 0) ? hi_q[0] : lo_q[0]);
      tick();
      if (hi_q.size() > 0) void'(hi_q.pop_front());
      else void'(lo_q.pop_front());
    end
    out_ready = 1'b0;
    check("mid_count5", count, 5);
    do_start();
    check("mid_out_valid", out_valid, 0);
    check("mid_overflow", overflow, 0);
    check("mid_done", done, 0);

    // Reset mid-COLLECT
    send(4'b0110, {gen_move(3), gen_move(3), gen_move(3), gen_move(3)});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_in_ready", in_ready, 0);
    check("rst2_count", count, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_move", out_move, 0);
    check("rst2_overflow", overflow, 0);
    check("rst2_done", done, 0);
    tick();
    check("rst2_idle", in_ready, 0);
    do_start();
    send(4'b1000, {gen_move(2), 48'h0});
    finish_pass(1);
    drain(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/move_list_buffer.md
# move_list_buffer

Collects the formatted 16-bit moves produced by the per-square move checkers during one generation pass and buffers them. During readout it presents them to the search controller in capture/promotion-first order. It sits directly downstream of the move checker array and upstream of the search controller. It accepts a bundle of up to NUM_PORTS moves per handshake, serialises each bundle into two priority queues, and drains them through a valid/ready interface once generation is complete.

## Interface
- NUM_PORTS, 4, number of move checker outputs captured per bundle
- DEPTH, 32, entries per priority queue (power of two)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse: clear buffer and begin a generation pass
- gen_done  input  1  one-cycle pulse: upstream has presented its last bundle
- in_valid  input  NUM_PORTS  per-port move valid (checker `valid`)
- in_move  input  16*NUM_PORTS  port i occupies bits [16i+15:16i], format {1'b0, castle, promo, capture, src_col, src_row, dest_col, dest_row}
- in_ready  output  1  staging register empty and state is COLLECT
- out_valid  output  1  a move is presented on out_move
- out_move  output  16  head move
- out_ready  input  1  consumer takes out_move when out_valid & out_ready
- count  output  $clog2(2*DEPTH)+1  total entries in both queues
- overflow  output  1  sticky: at least one move was dropped this pass
- done  output  1  high in IDLE after a completed drain; cleared by start

## Operation
- States: IDLE, COLLECT, FLUSH, DRAIN.
- IDLE -> COLLECT on start.
- start in any state: queues emptied, staging cleared, overflow and done cleared, next state COLLECT.
- COLLECT:
  - A bundle is accepted when in_ready is high and |in_valid is true. in_move and in_valid are copied into the staging register and pending mask.
  - An all-zero in_valid is ignored.
  - Port inputs are not sampled while in_ready is low; upstream must hold them.
- Serialiser, active in COLLECT and FLUSH: each cycle the lowest-index set pending bit is cleared and its move is written to a queue.
  - Moves with bit 12 (capture) or bit 13 (promo) set go to the HI queue. All others go to the LO queue.
  - If the target queue is full, the move is discarded, overflow is set, and the pending bit is still cleared, so the serialiser cannot deadlock.
- COLLECT -> FLUSH on gen_done. A gen_done in the same cycle as a bundle accept still accepts that bundle.
- FLUSH -> DRAIN when the pending mask is zero. The transition is immediate if the mask is already zero.
- gen_done outside COLLECT is ignored.
- DRAIN:
  - out_valid is high while either queue is non-empty.
  - out_move is the HI head if HI is non-empty, otherwise the LO head.
  - Each queue pops in FIFO order on out_valid & out_ready.
- DRAIN -> IDLE with done=1 on the cycle both queues are empty. An empty pass goes DRAIN -> IDLE in one cycle.
- Writes and reads never overlap, because writes occur only in COLLECT/FLUSH and reads only in DRAIN.
- Queue pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A per-queue occupancy counter of $clog2(DEPTH)+1 bits distinguishes full from empty. count is the sum of the two counters.
- overflow never clears except by start or reset.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, out_move=0, count=0, overflow=0, done=0, pending mask 0, all pointers 0.
- Accept at edge N. The first move is written at edge N+1 and count increments after edge N+1. A bundle of k valid moves finishes writing at edge N+k.
- in_ready goes high the cycle after the last pending bit clears, so back-to-back bundles with a single valid move can be accepted every 2 cycles.
- out_move/out_valid are combinational from queue heads and state. A pop at edge M presents the next move after edge M. Sustained throughput is 1 move/cycle.
- rst_n low at any edge overrides start and all other activity.

## Test plan
- Reset then start: one bundle with in_valid=4'b1011, moves A (quiet), B (capture bit 12), D (quiet) -> written over 3 cycles in order A, B, D; count=3; after gen_done and drain with out_ready=1, outputs B, A, D, then done=1.
- Promo priority: quiet 0x0123 followed by promo 0x2456 in separate bundles -> drain outputs 0x2456 first, then 0x0123.
- Overflow: DEPTH+2 capture moves -> count=DEPTH, overflow=1, serialiser still finishes and reaches DRAIN, DEPTH moves drained in arrival order.
- gen_done same cycle as a 4-move accept -> FLUSH for 4 cycles, then DRAIN; all 4 moves present; no port sampled during FLUSH.
- Backpressure: out_ready toggled 1,0,0,1 -> out_move held stable while out_ready=0; no duplicated or lost moves.
- start mid-DRAIN with 5 entries left -> next cycle count=0, out_valid=0, state COLLECT, overflow=0; rst_n low mid-COLLECT -> all reset values.
